// File: rtl/deb_pkg.sv
// Shared types and helpers for the debouncer bank.
package deb_pkg;

   typedef enum logic {
      TICK_INT = 1'b0,
      TICK_EXT = 1'b1
   } tick_src_e;

   // Width of a counter that must hold the values 0..deb_len.
   function automatic int unsigned cnt_w(input int unsigned deb_len);
      return $clog2(deb_len + 1);
   endfunction

endpackage

// File: rtl/deb_chan.sv
// One debouncer channel: synchroniser, qualification counter, debounced level,
// registered edge pulses and sticky change flag.
module deb_chan
   import deb_pkg::*;
#(
   parameter int unsigned DEB_LEN = 10,
   parameter int unsigned DLY_LEN = 2,
   parameter logic        RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic in,
   input  logic en,
   input  logic clr,
   output logic out,
   output logic rise,
   output logic fall,
   output logic chg
);

   localparam int unsigned      CNT_W    = cnt_w(DEB_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_LEN - 1);

   logic [DLY_LEN-1:0] sync;
   logic [CNT_W-1:0]   cnt;
   logic               s;
   logic               differ;
   logic               flip;

   assign s      = sync[DLY_LEN-1];
   assign differ = tick && en && (s != out);
   assign flip   = differ && (cnt == CNT_LAST);

   // Synchroniser runs every clk, independent of the sample tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= {DLY_LEN{RST_VAL}};
      end else begin
         sync <= {sync[DLY_LEN-2:0], in};
      end
   end

   // Any agreeing or disabled tick restarts qualification; the count never passes CNT_LAST.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         out <= RST_VAL;
      end else if (tick) begin
         if (flip || !differ) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         if (flip) begin
            out <= s;
         end
      end
   end

   // Pulses cover the cycle after the flip; chg latches them until cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
         chg  <= 1'b0;
      end else begin
         rise <= flip && s;
         fall <= flip && !s;
         chg  <= rise || fall || (chg && !clr);
      end
   end

endmodule

// File: rtl/deb_bank.sv
// Multi-channel debouncer bank: shared sample tick (prescaler or external strobe),
// one deb_chan per channel and an OR-reduced interrupt.
module deb_bank
   import deb_pkg::*;
#(
   parameter int unsigned    CH           = 8,
   parameter int unsigned    DEB_LEN      = 10,
   parameter int unsigned    DLY_LEN      = 2,
   parameter int unsigned    USE_EXT_TICK = 0,
   parameter int unsigned    PRESCALE     = 1,
   parameter logic [CH-1:0]  RST_VAL      = {CH{1'b1}}
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] in,
   input  logic          shift,
   input  logic [CH-1:0] en,
   input  logic [CH-1:0] clr,
   output logic [CH-1:0] out,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall,
   output logic [CH-1:0] chg,
   output logic          irq
);

   localparam tick_src_e         TICK_SRC  = (USE_EXT_TICK != 0) ? TICK_EXT : TICK_INT;
   localparam int unsigned       PCNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

   logic [PCNT_W-1:0] pcnt;
   logic              tick_int;
   logic              tick;

   // With PRESCALE=1 pcnt stays at 0 and the internal tick is constantly high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt <= '0;
      end else if (pcnt == PCNT_LAST) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PCNT_W'(1);
      end
   end

   assign tick_int = (pcnt == PCNT_LAST);
   assign tick     = (TICK_SRC == TICK_EXT) ? shift : tick_int;

   for (genvar i = 0; i < CH; i++) begin : g_chan
      deb_chan #(
         .DEB_LEN (DEB_LEN),
         .DLY_LEN (DLY_LEN),
         .RST_VAL (RST_VAL[i])
      ) u_chan (
         .clk  (clk),
         .rst  (rst),
         .tick (tick),
         .in   (in[i]),
         .en   (en[i]),
         .clr  (clr[i]),
         .out  (out[i]),
         .rise (rise[i]),
         .fall (fall[i]),
         .chg  (chg[i])
      );
   end

   assign irq = |chg;

endmodule
